// File: rtl/vid_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// vid_pkg: shared encodings, luma weights and default timing constants
// Rev 1.0
// ------------------------------------------------------------------
package vid_pkg;

  typedef enum logic [1:0] {
    MONO_COLOR = 2'b00,
    MONO_GREEN = 2'b01,
    MONO_AMBER = 2'b10,
    MONO_WHITE = 2'b11
  } mono_mode_e;

  typedef struct packed {
    logic hblank;
    logic hsync;
    logic vblank;
    logic vsync;
  } vid_flags_t;

  localparam int LUMA_WR    = 54;
  localparam int LUMA_WG    = 183;
  localparam int LUMA_WB    = 19;
  localparam int LUMA_SHIFT = 8;

  localparam int H_TOTAL_DEF  = 638;
  localparam int H_BLANK_DEF  = 529;
  localparam int HS_START_DEF = 544;
  localparam int HS_END_DEF   = 590;

  localparam int NTSC_VT_DEF  = 262;
  localparam int NTSC_VB_DEF  = 240;
  localparam int NTSC_VS0_DEF = 245;
  localparam int NTSC_VS1_DEF = 248;

  localparam int PAL_VT_DEF   = 312;
  localparam int PAL_VB_DEF   = 300;
  localparam int PAL_VS0_DEF  = 304;
  localparam int PAL_VS1_DEF  = 308;

  // Vertical constants are given at single line rate; doubled rate scales every one.
  function automatic int vline(input int base, input logic dbl);
    return dbl ? base * 2 : base;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vid_luma.sv
`default_nettype none
// ------------------------------------------------------------------
// vid_luma: two-stage RGB register / luma / mono-mode output pipe
// Rev 1.0
// ------------------------------------------------------------------
module vid_luma
  import vid_pkg::*;
#(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  input  logic [1:0]    mono_mode,
  input  logic          blank,
  input  logic [CW-1:0] r_in,
  input  logic [CW-1:0] g_in,
  input  logic [CW-1:0] b_in,
  output logic [CW-1:0] r_out,
  output logic [CW-1:0] g_out,
  output logic [CW-1:0] b_out
);

  localparam logic [CW+7:0] WR = (CW+8)'(LUMA_WR);
  localparam logic [CW+7:0] WG = (CW+8)'(LUMA_WG);
  localparam logic [CW+7:0] WB = (CW+8)'(LUMA_WB);

  logic [CW-1:0] r1_q, r1_d, g1_q, g1_d, b1_q, b1_d;
  logic [CW-1:0] r2_q, r2_d, g2_q, g2_d, b2_q, b2_d;
  logic [CW+7:0] pr, pg, pb;
  logic [CW+8:0] sum;
  logic [CW-1:0] y;

  // Weights sum to 256, so full-scale input lands exactly on full scale.
  always_comb begin
    pr  = WR * {8'd0, r1_q};
    pg  = WG * {8'd0, g1_q};
    pb  = WB * {8'd0, b1_q};
    sum = {1'b0, pr} + {1'b0, pg} + {1'b0, pb};
    y   = CW'(sum >> LUMA_SHIFT);
  end

  always_comb begin
    r1_d = r1_q;
    g1_d = g1_q;
    b1_d = b1_q;
    r2_d = r2_q;
    g2_d = g2_q;
    b2_d = b2_q;
    if (ce) begin
      r1_d = r_in;
      g1_d = g_in;
      b1_d = b_in;
      if (blank) begin
        r2_d = '0;
        g2_d = '0;
        b2_d = '0;
      end else begin
        case (mono_mode_e'(mono_mode))
          MONO_COLOR: begin
            r2_d = r1_q;
            g2_d = g1_q;
            b2_d = b1_q;
          end
          MONO_GREEN: begin
            r2_d = '0;
            g2_d = y;
            b2_d = '0;
          end
          MONO_AMBER: begin
            r2_d = y;
            g2_d = y >> 1;
            b2_d = '0;
          end
          default: begin
            r2_d = y;
            g2_d = y;
            b2_d = y;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r1_q <= '0;
      g1_q <= '0;
      b1_q <= '0;
      r2_q <= '0;
      g2_q <= '0;
      b2_q <= '0;
    end else begin
      r1_q <= r1_d;
      g1_q <= g1_d;
      b1_q <= b1_d;
      r2_q <= r2_d;
      g2_q <= g2_d;
      b2_q <= b2_d;
    end
  end

  assign r_out = r2_q;
  assign g_out = g2_q;
  assign b_out = b2_q;

endmodule
`default_nettype wire

// File: rtl/vid_timing_mono.sv
`default_nettype none
// ------------------------------------------------------------------
// vid_timing_mono: NTSC/PAL timing generator with mono colour pipeline
// Rev 1.0
// ------------------------------------------------------------------
module vid_timing_mono
  import vid_pkg::*;
#(
  parameter int CW       = 6,
  parameter int HW       = 10,
  parameter int H_TOTAL  = H_TOTAL_DEF,
  parameter int H_BLANK  = H_BLANK_DEF,
  parameter int HS_START = HS_START_DEF,
  parameter int HS_END   = HS_END_DEF,
  parameter int NTSC_VT  = NTSC_VT_DEF,
  parameter int NTSC_VB  = NTSC_VB_DEF,
  parameter int NTSC_VS0 = NTSC_VS0_DEF,
  parameter int NTSC_VS1 = NTSC_VS1_DEF,
  parameter int PAL_VT   = PAL_VT_DEF,
  parameter int PAL_VB   = PAL_VB_DEF,
  parameter int PAL_VS0  = PAL_VS0_DEF,
  parameter int PAL_VS1  = PAL_VS1_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pal,
  input  logic          scandouble,
  input  logic [1:0]    mono_mode,
  input  logic [CW-1:0] r_in,
  input  logic [CW-1:0] g_in,
  input  logic [CW-1:0] b_in,
  output logic          ce_pix,
  output logic [HW-1:0] hc,
  output logic [HW-1:0] vc,
  output logic          HBlank,
  output logic          HSync,
  output logic          VBlank,
  output logic          VSync,
  output logic [CW-1:0] r_out,
  output logic [CW-1:0] g_out,
  output logic [CW-1:0] b_out,
  output logic [7:0]    frame_cnt
);

  localparam logic [HW-1:0] ONE = HW'(1);

  logic          ce_q, ce_d;
  logic [HW-1:0] hc_q, hc_d, vc_q, vc_d;
  logic [7:0]    frame_q, frame_d;
  logic          pal_l_q, pal_l_d, sd_l_q, sd_l_d;
  vid_flags_t    raw_q, raw_d, dl1_q, dl1_d, dl2_q, dl2_d;
  logic [HW-1:0] vt, vb, vs0, vs1;
  logic          h_wrap, v_wrap;

  always_comb begin
    vt  = HW'(vline(pal_l_q ? PAL_VT  : NTSC_VT,  sd_l_q));
    vb  = HW'(vline(pal_l_q ? PAL_VB  : NTSC_VB,  sd_l_q));
    vs0 = HW'(vline(pal_l_q ? PAL_VS0 : NTSC_VS0, sd_l_q));
    vs1 = HW'(vline(pal_l_q ? PAL_VS1 : NTSC_VS1, sd_l_q));
  end

  always_comb begin
    ce_d    = sd_l_q | ~ce_q;
    hc_d    = hc_q;
    vc_d    = vc_q;
    frame_d = frame_q;
    pal_l_d = pal_l_q;
    sd_l_d  = sd_l_q;
    raw_d   = raw_q;
    dl1_d   = dl1_q;
    dl2_d   = dl2_q;
    h_wrap  = (hc_q == HW'(H_TOTAL - 1));
    v_wrap  = (vc_q == (vt - ONE));
    if (ce_q) begin
      hc_d = h_wrap ? '0 : hc_q + ONE;
      if (h_wrap) begin
        if (v_wrap) begin
          vc_d    = '0;
          frame_d = frame_q + 8'd1;
          pal_l_d = pal;
          sd_l_d  = scandouble;
        end else begin
          vc_d = vc_q + ONE;
        end
      end
      // Raw flags follow the next counter values so they stay aligned with hc/vc.
      if (hc_d == HW'(H_BLANK))       raw_d.hblank = 1'b1;
      else if (hc_d == '0)            raw_d.hblank = 1'b0;
      if (hc_d == HW'(HS_START))      raw_d.hsync  = 1'b1;
      else if (hc_d == HW'(HS_END))   raw_d.hsync  = 1'b0;
      if (hc_d == HW'(HS_START)) begin
        if (vc_d == vb)               raw_d.vblank = 1'b1;
        else if (vc_d == '0)          raw_d.vblank = 1'b0;
        if (vc_d == vs0)              raw_d.vsync  = 1'b1;
        else if (vc_d == vs1)         raw_d.vsync  = 1'b0;
      end
      dl1_d = raw_q;
      dl2_d = dl1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ce_q    <= 1'b0;
      hc_q    <= '0;
      vc_q    <= '0;
      frame_q <= '0;
      pal_l_q <= pal;
      sd_l_q  <= scandouble;
      raw_q   <= '0;
      dl1_q   <= '0;
      dl2_q   <= '0;
    end else begin
      ce_q    <= ce_d;
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      frame_q <= frame_d;
      pal_l_q <= pal_l_d;
      sd_l_q  <= sd_l_d;
      raw_q   <= raw_d;
      dl1_q   <= dl1_d;
      dl2_q   <= dl2_d;
    end
  end

  // Blanking is taken one stage early so the zeroed colour lines up with dl2 flags.
  vid_luma #(
    .CW(CW)
  ) u_luma (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce_q),
    .mono_mode (mono_mode),
    .blank     (dl1_q.hblank | dl1_q.vblank),
    .r_in      (r_in),
    .g_in      (g_in),
    .b_in      (b_in),
    .r_out     (r_out),
    .g_out     (g_out),
    .b_out     (b_out)
  );

  assign ce_pix    = ce_q;
  assign hc        = hc_q;
  assign vc        = vc_q;
  assign frame_cnt = frame_q;
  assign HBlank    = dl2_q.hblank;
  assign HSync     = dl2_q.hsync;
  assign VBlank    = dl2_q.vblank;
  assign VSync     = dl2_q.vsync;

endmodule
`default_nettype wire

// File: tb/tb_vid_timing_mono.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_vid_timing_mono: random-stimulus bench with a pixel-level reference model
// Rev 1.0
// ------------------------------------------------------------------
module tb_vid_timing_mono;

  localparam int CW = 6, HW = 10;
  localparam int H_TOTAL = 40, H_BLANK = 33, HS_START = 34, HS_END = 37;
  localparam int NTSC_VT = 22, NTSC_VB = 18, NTSC_VS0 = 19, NTSC_VS1 = 20;
  localparam int PAL_VT  = 27, PAL_VB  = 23, PAL_VS0  = 24, PAL_VS1  = 26;

  logic          clk = 1'b0;
  logic          reset = 1'b1, pal = 1'b0, scandouble = 1'b0;
  logic [1:0]    mono_mode = 2'd0;
  logic [CW-1:0] r_in = '0, g_in = '0, b_in = '0;
  logic          ce_pix, HBlank, HSync, VBlank, VSync;
  logic [HW-1:0] hc, vc;
  logic [CW-1:0] r_out, g_out, b_out;
  logic [7:0]    frame_cnt;

  vid_timing_mono #(
    .CW(CW), .HW(HW), .H_TOTAL(H_TOTAL), .H_BLANK(H_BLANK),
    .HS_START(HS_START), .HS_END(HS_END),
    .NTSC_VT(NTSC_VT), .NTSC_VB(NTSC_VB), .NTSC_VS0(NTSC_VS0), .NTSC_VS1(NTSC_VS1),
    .PAL_VT(PAL_VT), .PAL_VB(PAL_VB), .PAL_VS0(PAL_VS0), .PAL_VS1(PAL_VS1)
  ) dut (
    .clk(clk), .reset(reset), .pal(pal), .scandouble(scandouble), .mono_mode(mono_mode),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .ce_pix(ce_pix), .hc(hc), .vc(vc),
    .HBlank(HBlank), .HSync(HSync), .VBlank(VBlank), .VSync(VSync),
    .r_out(r_out), .g_out(g_out), .b_out(b_out), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int wraps[$];
  int prev_vc = 0;
  bit rand_pix = 1'b1;

  // Reference model: pixel position, latched standard, and a 2-deep pixel pipe.
  int m_ce = 0, m_h = 0, m_v = 0, m_frame = 0, m_pal = 0, m_sd = 0, m_prev = 0;
  int s1_r = 0, s1_g = 0, s1_b = 0, o_r = 0, o_g = 0, o_b = 0;
  logic [3:0] s1_fl = '0, o_fl = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int vconst(input int ntsc, input int pl);
    return (m_pal != 0 ? pl : ntsc) * (m_sd != 0 ? 2 : 1);
  endfunction

  // Flags {hblank,hsync,vblank,vsync} belonging to pixel (h,v).
  function automatic logic [3:0] model_flags(input int h, input int v);
    logic hb, hs, vb, vs;
    int ev;
    hb = (h >= H_BLANK);
    hs = (h >= HS_START) && (h < HS_END);
    ev = (h >= HS_START) ? v : v - 1;
    if (ev < 0) begin
      // start of line 0: still showing the previous frame's last line, if there was one
      vb = (m_prev != 0);
      vs = 1'b0;
    end else begin
      vb = (ev >= vconst(NTSC_VB, PAL_VB));
      vs = (ev >= vconst(NTSC_VS0, PAL_VS0)) && (ev < vconst(NTSC_VS1, PAL_VS1));
    end
    return {hb, hs, vb, vs};
  endfunction

  task automatic model_edge();
    int ce_old, y, vt;
    if (reset) begin
      m_ce = 0; m_h = 0; m_v = 0; m_frame = 0; m_prev = 0;
      m_pal = int'(pal); m_sd = int'(scandouble);
      s1_r = 0; s1_g = 0; s1_b = 0; s1_fl = '0;
      o_r = 0; o_g = 0; o_b = 0; o_fl = '0;
    end else begin
      ce_old = m_ce;
      m_ce = (m_sd != 0) ? 1 : (ce_old == 0 ? 1 : 0);
      if (ce_old != 0) begin
        o_fl = s1_fl;
        y = (54 * s1_r + 183 * s1_g + 19 * s1_b) / 256;
        if (s1_fl[3] || s1_fl[1]) begin
          o_r = 0; o_g = 0; o_b = 0;
        end else begin
          case (mono_mode)
            2'd0: begin o_r = s1_r; o_g = s1_g; o_b = s1_b; end
            2'd1: begin o_r = 0;    o_g = y;    o_b = 0;    end
            2'd2: begin o_r = y;    o_g = y / 2; o_b = 0;   end
            default: begin o_r = y; o_g = y;    o_b = y;    end
          endcase
        end
        s1_r = int'(r_in); s1_g = int'(g_in); s1_b = int'(b_in);
        s1_fl = model_flags(m_h, m_v);
        vt = vconst(NTSC_VT, PAL_VT);
        if (m_h == H_TOTAL - 1) begin
          m_h = 0;
          if (m_v == vt - 1) begin
            m_v = 0; m_frame = (m_frame + 1) % 256; m_prev = 1;
            m_pal = int'(pal); m_sd = int'(scandouble);
          end else begin
            m_v++;
          end
        end else begin
          m_h++;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("ce_pix", ce_pix, m_ce);
    check_eq("hc", hc, m_h);
    check_eq("vc", vc, m_v);
    check_eq("frame_cnt", frame_cnt, m_frame);
    check_eq("flags", {HBlank, HSync, VBlank, VSync}, o_fl);
    check_eq("rgb", {r_out, g_out, b_out}, o_r * 4096 + o_g * 64 + o_b);
    if (vc == 0 && prev_vc != 0) wraps.push_back(prev_vc);
    prev_vc = int'(vc);
    if (rand_pix) begin
      r_in = CW'($urandom_range(0, 63));
      g_in = CW'($urandom_range(0, 63));
      b_in = CW'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) mono_mode = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic do_reset(input logic p, input logic sd, input int n);
    reset = 1'b1; pal = p; scandouble = sd;
    repeat (n) step();
    reset = 1'b0;
    wraps.delete();
  endtask

  task automatic wait_pos(input string tag, input int h, input int vmin, input int vmax);
    int guard = 0;
    while (!(m_h == h && m_v >= vmin && m_v < vmax && m_ce != 0) && guard < 6000) begin
      step();
      guard++;
    end
    check_eq({tag, "_reached"}, guard < 6000, 1);
  endtask

  task automatic probe(input string tag, input int r, input int g, input int b,
                       input int mode, input int er, input int eg, input int eb);
    wait_pos(tag, 2, 1, 40);
    rand_pix = 1'b0;
    r_in = CW'(r); g_in = CW'(g); b_in = CW'(b); mono_mode = 2'(mode);
    repeat (3) step();
    check_eq(tag, {r_out, g_out, b_out}, er * 4096 + eg * 64 + eb);
    rand_pix = 1'b1;
  endtask

  initial begin
    bit toggled = 1'b0;

    // NTSC single rate; pal flips mid-frame and must only take effect next frame.
    do_reset(1'b0, 1'b0, 2);
    for (int i = 0; i < 4200; i++) begin
      if (!toggled && m_frame == 0 && m_v == 10) begin
        pal = 1'b1;
        toggled = 1'b1;
      end
      step();
    end
    check_eq("a_frame1_last_line", wraps.size() > 0 ? wraps[0] : -1, NTSC_VT - 1);
    check_eq("a_frame2_last_line", wraps.size() > 1 ? wraps[1] : -1, PAL_VT - 1);

    // PAL doubled line rate.
    do_reset(1'b1, 1'b1, 2);
    for (int i = 0; i < 4600; i++) step();
    check_eq("b_frame1_last_line", wraps.size() > 0 ? wraps[0] : -1, 2 * PAL_VT - 1);
    check_eq("b_frame2_last_line", wraps.size() > 1 ? wraps[1] : -1, 2 * PAL_VT - 1);
    check_eq("b_frame_cnt", frame_cnt, 2);

    // Directed luma/mode values in the active area.
    probe("white_full",  63, 63, 63, 3, 63, 63, 63);
    probe("white_red",   63,  0,  0, 3, 13, 13, 13);
    probe("white_blue",   0,  0, 63, 3,  4,  4,  4);
    probe("amber_green",  0, 63,  0, 2, 45, 22,  0);
    probe("green_green",  0, 63,  0, 1,  0, 45,  0);
    probe("color_green",  0, 63,  0, 0,  0, 63,  0);

    // Colour inside horizontal blanking is forced to zero.
    wait_pos("hblank", H_BLANK, 1, 40);
    rand_pix = 1'b0;
    r_in = 6'd63; g_in = 6'd63; b_in = 6'd63; mono_mode = 2'd3;
    repeat (3) step();
    check_eq("hblank_flag", HBlank, 1);
    check_eq("hblank_rgb", {r_out, g_out, b_out}, 0);
    rand_pix = 1'b1;

    // Mid-line reset.
    wait_pos("midline", 19, 1, 40);
    reset = 1'b1; pal = 1'b0; scandouble = 1'b0;
    step();
    check_eq("rst_hc", hc, 0);
    check_eq("rst_vc", vc, 0);
    check_eq("rst_ce", ce_pix, 0);
    check_eq("rst_flags", {HBlank, HSync, VBlank, VSync}, 0);
    check_eq("rst_rgb", {r_out, g_out, b_out}, 0);
    check_eq("rst_frame", frame_cnt, 0);
    reset = 1'b0;
    wraps.delete();
    step();
    check_eq("post_rst_ce", ce_pix, 1);
    for (int i = 0; i < 3600; i++) step();
    check_eq("d_frame1_last_line", wraps.size() > 0 ? wraps[0] : -1, NTSC_VT - 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
